// File: rtl/zc_period_tracker.sv
// Zero-cross period tracker: synchronises and debounces the mirror zero-cross, measures its
// period, averages it over a sliding window and reports lock status to the laser synchronizer.
module zc_period_tracker #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned AVG_LOG2        = 2,
   parameter int unsigned PERIOD_MIN      = 10000,
   parameter int unsigned PERIOD_MAX      = 100000,
   parameter int unsigned ERR_LIMIT       = 2
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        zc_raw_i,
   input  logic        enable_i,
   output logic        zc_o,
   output logic [23:0] freq_o,
   output logic        freq_valid_o,
   output logic        locked_o,
   output logic        period_err_o
);

   localparam int unsigned WIN = 1 << AVG_LOG2;
   localparam int unsigned SW  = 24 + AVG_LOG2;
   localparam int unsigned DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned EW  = $clog2(ERR_LIMIT + 1);
   localparam int unsigned GW  = AVG_LOG2 + 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [23:0]   P_MIN     = 24'(PERIOD_MIN);
   localparam logic [23:0]   P_MAX     = 24'(PERIOD_MAX);
   localparam logic [23:0]   P_TIMEOUT = 24'(PERIOD_MAX + 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT);
   localparam logic [GW-1:0] GOOD_FULL = GW'(WIN);

   typedef enum logic [1:0] {StIdle, StAcquire, StMeasure, StLocked} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   filt_q, filt_d, filt_dly_q, zc_q;
   logic [DW-1:0]          db_cnt_q, db_cnt_d;
   logic [23:0]            per_q, per_d;
   logic [23:0]            win_q [WIN];
   logic [23:0]            win_d [WIN];
   logic [SW-1:0]          sum_q, sum_d, sum_push;
   logic [GW-1:0]          good_q, good_d, good_inc;
   logic [EW-1:0]          err_cnt_q, err_cnt_d, err_inc;
   logic [23:0]            freq_q, freq_d;
   logic                   perr_q, perr_d;
   logic                   sync_s, in_range, timeout, push, upd_freq, flush;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Any sample equal to the filtered level restarts the stability count.
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = '0;
      if (sync_s != filt_q) begin
         if (db_cnt_q == DB_LAST) filt_d = sync_s;
         else                     db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   assign in_range = (per_q >= P_MIN) && (per_q <= P_MAX);
   assign timeout  = !zc_q && (per_q >= P_TIMEOUT);
   assign sum_push = sum_q + SW'(per_q) - SW'(win_q[WIN-1]);
   assign good_inc = good_q + 1'b1;
   assign err_inc  = err_cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      sum_d     = sum_q;
      good_d    = good_q;
      err_cnt_d = err_cnt_q;
      freq_d    = freq_q;
      perr_d    = 1'b0;
      push      = 1'b0;
      upd_freq  = 1'b0;
      flush     = 1'b0;
      per_d     = zc_q ? 24'd1 : ((per_q == '1) ? per_q : per_q + 24'd1);

      unique case (state_q)
         StIdle: begin
            if (enable_i) state_d = StAcquire;
         end
         StAcquire: begin
            // First edge is only a timing reference.
            if (zc_q) state_d = StMeasure;
         end
         StMeasure: begin
            if (zc_q) begin
               if (in_range) begin
                  push   = 1'b1;
                  good_d = good_inc;
                  if (good_inc == GOOD_FULL) begin
                     state_d   = StLocked;
                     upd_freq  = 1'b1;
                     err_cnt_d = '0;
                  end
               end else begin
                  perr_d = 1'b1;
                  flush  = 1'b1;
               end
            end else if (timeout) begin
               perr_d  = 1'b1;
               flush   = 1'b1;
               state_d = StAcquire;
            end
         end
         StLocked: begin
            if (zc_q) begin
               if (per_q >= P_TIMEOUT) begin
                  // Edge coinciding with the timeout: treated as a late edge, not a timeout.
                  perr_d  = 1'b1;
                  flush   = 1'b1;
                  state_d = StMeasure;
               end else if (in_range) begin
                  push      = 1'b1;
                  upd_freq  = 1'b1;
                  err_cnt_d = '0;
               end else begin
                  perr_d = 1'b1;
                  if (err_inc == ERR_LAST) begin
                     flush   = 1'b1;
                     state_d = StMeasure;
                  end else begin
                     err_cnt_d = err_inc;
                  end
               end
            end else if (timeout) begin
               perr_d  = 1'b1;
               flush   = 1'b1;
               state_d = StAcquire;
            end
         end
         default: state_d = StIdle;
      endcase

      if (!enable_i) begin
         state_d  = StIdle;
         push     = 1'b0;
         upd_freq = 1'b0;
         flush    = 1'b1;
         perr_d   = 1'b0;
      end

      if (push) begin
         win_d[0] = per_q;
         for (int unsigned i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
         sum_d = sum_push;
      end
      if (upd_freq) freq_d = 24'(sum_push >> AVG_LOG2);
      if (flush) begin
         win_d     = '{default: '0};
         sum_d     = '0;
         good_d    = '0;
         err_cnt_d = '0;
      end
      if (!enable_i) freq_d = '0;
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q    <= StIdle;
         sync_q     <= '0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         zc_q       <= 1'b0;
         db_cnt_q   <= '0;
         per_q      <= '0;
         win_q      <= '{default: '0};
         sum_q      <= '0;
         good_q     <= '0;
         err_cnt_q  <= '0;
         freq_q     <= '0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], zc_raw_i};
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         zc_q       <= filt_q & ~filt_dly_q;
         db_cnt_q   <= db_cnt_d;
         per_q      <= per_d;
         win_q      <= win_d;
         sum_q      <= sum_d;
         good_q     <= good_d;
         err_cnt_q  <= err_cnt_d;
         freq_q     <= freq_d;
         perr_q     <= perr_d;
      end
   end

   assign zc_o         = zc_q;
   assign freq_o       = freq_q;
   assign locked_o     = (state_q == StLocked);
   assign freq_valid_o = (state_q == StLocked);
   assign period_err_o = perr_q;

endmodule
